// File: rtl/muldiv_ctrl.sv
// MULT/DIV sequencer: latches operands, runs the unit start/done handshake,
// owns architectural Hi/Lo, screens zero divisors and aborts hung units.
module muldiv_ctrl #(
    parameter int TIMEOUT = 48
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic        OpMult,
    input  logic        OpDiv,
    input  logic [31:0] OperandoA,
    input  logic [31:0] OperandoB,
    output logic [31:0] UnitA,
    output logic [31:0] UnitB,
    output logic        MultStart,
    output logic        DivStart,
    input  logic        MultFim,
    input  logic        DivFim,
    input  logic        DivisaoPorZero,
    input  logic [31:0] MultHi,
    input  logic [31:0] MultLo,
    input  logic [31:0] DivHi,
    input  logic [31:0] DivLo,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Ocupado,
    output logic        Pronto,
    output logic        ExcecaoDivZero,
    output logic        Erro
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MULT,
        S_WAIT_DIV,
        S_DRAIN,
        S_EXC
    } state_t;

    state_t         r_state;
    logic           r_is_div;
    logic           r_exc;
    logic [WDW-1:0] r_wd;

    logic           w_fim;
    logic [31:0]    w_hi;
    logic [31:0]    w_lo;
    logic           w_wd_exp;

    assign w_fim    = r_is_div ? DivFim : MultFim;
    assign w_hi     = r_is_div ? DivHi  : MultHi;
    assign w_lo     = r_is_div ? DivLo  : MultLo;
    assign w_wd_exp = (r_wd >= WDW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state        <= S_IDLE;
            r_is_div       <= 1'b0;
            r_exc          <= 1'b0;
            r_wd           <= '0;
            UnitA          <= '0;
            UnitB          <= '0;
            MultStart      <= 1'b0;
            DivStart       <= 1'b0;
            Hi             <= '0;
            Lo             <= '0;
            Ocupado        <= 1'b0;
            Pronto         <= 1'b0;
            ExcecaoDivZero <= 1'b0;
            Erro           <= 1'b0;
        end else begin
            Pronto         <= 1'b0;
            ExcecaoDivZero <= 1'b0;
            Erro           <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wd <= '0;
                    if (OpDiv) begin
                        Ocupado <= 1'b1;
                        if (OperandoB == '0) begin
                            ExcecaoDivZero <= 1'b1;
                            r_state        <= S_EXC;
                        end else begin
                            UnitA    <= OperandoA;
                            UnitB    <= OperandoB;
                            r_is_div <= 1'b1;
                            r_exc    <= 1'b0;
                            DivStart <= 1'b1;
                            r_state  <= S_WAIT_DIV;
                        end
                    end else if (OpMult) begin
                        Ocupado   <= 1'b1;
                        UnitA     <= OperandoA;
                        UnitB     <= OperandoB;
                        r_is_div  <= 1'b0;
                        r_exc     <= 1'b0;
                        MultStart <= 1'b1;
                        r_state   <= S_WAIT_MULT;
                    end
                end
                S_WAIT_MULT, S_WAIT_DIV: begin
                    if (w_fim) begin
                        if (r_is_div && DivisaoPorZero) begin
                            ExcecaoDivZero <= 1'b1;
                            r_exc          <= 1'b1;
                        end else begin
                            Hi <= w_hi;
                            Lo <= w_lo;
                        end
                        r_wd    <= r_wd + WDW'(1);
                        r_state <= S_DRAIN;
                    end else if (w_wd_exp) begin
                        MultStart <= 1'b0;
                        DivStart  <= 1'b0;
                        Ocupado   <= 1'b0;
                        Erro      <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end
                S_DRAIN: begin
                    // Start is held until the unit lowers Fim so it can re-arm.
                    if (!w_fim) begin
                        MultStart <= 1'b0;
                        DivStart  <= 1'b0;
                        Ocupado   <= 1'b0;
                        Pronto    <= !r_exc;
                        r_state   <= S_IDLE;
                    end else if (w_wd_exp) begin
                        MultStart <= 1'b0;
                        DivStart  <= 1'b0;
                        Ocupado   <= 1'b0;
                        Erro      <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end
                S_EXC: begin
                    Ocupado <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    MultStart <= 1'b0;
                    DivStart  <= 1'b0;
                    Ocupado   <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
